// File: rtl/phy_tx_lane_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | phy_tx_lane_serializer: word FIFO, byte striping, per-lane serialiser|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module phy_tx_lane_serializer #(
  parameter int         DATA_W = 32,
  parameter int         LANES  = 2,
  parameter int         DEPTH  = 4,
  parameter logic [7:0] COM    = 8'hBC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [LANES-1:0]  data_out,
  output logic [LANES-1:0]  valid_out
);
  localparam int BYTES = DATA_W / 8;
  localparam int SLOTS = BYTES / LANES;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DATA_W-1:0]     r_word;
  logic [SW-1:0]         r_slot;
  logic [2:0]            r_bit_cnt;
  state_t                r_state;
  logic [LANES-1:0][7:0] r_shreg;
  logic [LANES-1:0]      r_valid;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_boundary;
  logic                  w_advance;
  logic                  w_pop;
  logic [DATA_W-1:0]     w_src_word;
  logic [SW-1:0]         w_src_slot;
  logic [LANES-1:0][7:0] w_load;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = valid_in && !w_full;
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_advance  = (r_state == S_BUSY) && (r_slot != LAST_SLOT);
  assign w_pop      = w_boundary && !w_advance && !w_empty;
  assign ready_out  = !w_full;
  assign valid_out  = r_valid;

  // Next word/slot to load: continue the held word, else the FIFO head at slot 0.
  assign w_src_word = w_advance ? r_word : r_mem[r_rd_ptr[AW-1:0]];
  assign w_src_slot = w_advance ? (r_slot + SLOT_ONE) : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_load[l]   = w_src_word[DATA_W-1-8*(int'(w_src_slot)*LANES + l) -: 8];
    assign data_out[l] = r_shreg[l][7];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_word    <= '0;
      r_slot    <= '0;
      r_bit_cnt <= 3'd0;
      r_state   <= S_IDLE;
      r_shreg   <= {LANES{COM}};
      r_valid   <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_boundary) begin
        if (w_advance) begin
          r_slot  <= r_slot + SLOT_ONE;
          r_shreg <= w_load;
          r_valid <= '1;
        end else if (w_pop) begin
          r_word   <= w_src_word;
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
          r_slot   <= '0;
          r_state  <= S_BUSY;
          r_shreg  <= w_load;
          r_valid  <= '1;
        end else begin
          r_slot  <= '0;
          r_state <= S_IDLE;
          r_shreg <= {LANES{COM}};
          r_valid <= '0;
        end
      end else begin
        for (int l = 0; l < LANES; l++) begin
          r_shreg[l] <= {r_shreg[l][6:0], 1'b0};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_lane_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_phy_tx_lane_serializer: directed bench over 1-, 2- and 4-lane DUTs|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_phy_tx_lane_serializer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d2_data, d4_data, d1_data;
  logic        d2_valid, d4_valid, d1_valid;
  logic        d2_ready, d4_ready, d1_ready;
  logic [1:0]  d2_dout, d2_vout;
  logic [3:0]  d4_dout, d4_vout;
  logic [0:0]  d1_dout, d1_vout;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cap [4];
  logic        vall, vnone;
  int          lat;
  int          widx, drop_at, vcnt, first_v, last_v, partial, nword, cyc;
  logic        pend;
  logic [15:0] s0, s1;
  logic [31:0] word;

  always #5 clk = ~clk;

  phy_tx_lane_serializer #(.DATA_W(32), .LANES(2), .DEPTH(4), .COM(8'hBC)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(d2_data), .valid_in(d2_valid),
    .ready_out(d2_ready), .data_out(d2_dout), .valid_out(d2_vout));
  phy_tx_lane_serializer #(.DATA_W(32), .LANES(4), .DEPTH(4), .COM(8'hBC)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(d4_data), .valid_in(d4_valid),
    .ready_out(d4_ready), .data_out(d4_dout), .valid_out(d4_vout));
  phy_tx_lane_serializer #(.DATA_W(32), .LANES(1), .DEPTH(4), .COM(8'hBC)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(d1_data), .valid_in(d1_valid),
    .ready_out(d1_ready), .data_out(d1_dout), .valid_out(d1_vout));

  function automatic logic [3:0] dout(input int sel);
    case (sel)
      1:       return {3'b000, d1_dout};
      4:       return d4_dout;
      default: return {2'b00, d2_dout};
    endcase
  endfunction

  function automatic logic [3:0] vout(input int sel);
    case (sel)
      1:       return {3'b000, d1_vout};
      4:       return d4_vout;
      default: return {2'b00, d2_vout};
    endcase
  endfunction

  function automatic logic [3:0] lmask(input int sel);
    case (sel)
      1:       return 4'h1;
      4:       return 4'hF;
      default: return 4'h3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shift ncyc samples of every lane into cap[], starting at the current negedge.
  task automatic collect(input int sel, input int ncyc);
    logic [3:0] d;
    logic [3:0] v;
    for (int l = 0; l < 4; l++) cap[l] = '0;
    vall  = 1'b1;
    vnone = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      d = dout(sel);
      v = vout(sel);
      for (int l = 0; l < 4; l++) cap[l] = {cap[l][30:0], d[l]};
      if (v !== lmask(sel)) vall = 1'b0;
      if (v !== 4'h0) vnone = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int sel, input string tag, output int n);
    n = 0;
    while (vout(sel) === 4'h0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(vout(sel) !== 4'h0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    d2_data = '0; d4_data = '0; d1_data = '0;
    d2_valid = 1'b0; d4_valid = 1'b0; d1_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout2",  32'(d2_dout),  32'h3);
    chk("rst_vout2",  32'(d2_vout),  32'h0);
    chk("rst_ready2", 32'(d2_ready), 32'h1);
    chk("rst_dout4",  32'(d4_dout),  32'hF);
    chk("rst_dout1",  32'(d1_dout),  32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    collect(2, 16);
    chk("idle_lane0", cap[0], 32'h0000BCBC);
    chk("idle_lane1", cap[1], 32'h0000BCBC);
    chk("idle_vnone", 32'(vnone), 32'd1);

    // Single word on two lanes, pushed at bit_cnt=0
    chk("single_ready", 32'(d2_ready), 32'd1);
    d2_data = 32'h11223344; d2_valid = 1'b1;
    @(negedge clk);
    d2_valid = 1'b0;
    wait_valid(2, "single_seen", lat);
    chk("single_latency", 32'(lat), 32'd7);
    collect(2, 16);
    chk("single_lane0", cap[0], 32'h00001133);
    chk("single_lane1", cap[1], 32'h00002244);
    chk("single_vall",  32'(vall), 32'd1);
    collect(2, 8);
    chk("single_com0", cap[0], 32'h000000BC);
    chk("single_com1", cap[1], 32'h000000BC);
    chk("single_vnone", 32'(vnone), 32'd1);

    // Back-to-back: eight words with valid held high
    widx = 0; pend = 1'b0; drop_at = -1; vcnt = 0; first_v = -1; last_v = -1;
    partial = 0; nword = 0; cyc = 0; s0 = '0; s1 = '0;
    while (cyc < 400 && !(vcnt == 128 && d2_vout == 2'b00)) begin
      if (d2_vout != 2'b00) begin
        if (d2_vout != 2'b11) partial++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        vcnt++;
        s0 = {s0[14:0], d2_dout[0]};
        s1 = {s1[14:0], d2_dout[1]};
        if (vcnt % 16 == 0) begin
          word = {s0[15:8], s1[15:8], s0[7:0], s1[7:0]};
          nword++;
          chk($sformatf("b2b_word%0d", nword), word, 32'(nword));
        end
      end
      if (pend) widx++;
      d2_data  = 32'(widx + 1);
      d2_valid = (widx < 8);
      if (!d2_ready && drop_at < 0) drop_at = widx;
      pend = d2_valid && d2_ready;
      @(negedge clk);
      cyc++;
    end
    d2_valid = 1'b0;
    chk("b2b_accepted", 32'(widx), 32'd8);
    chk("b2b_full_at",  32'(drop_at), 32'd4);
    chk("b2b_vcount",   32'(vcnt), 32'd128);
    chk("b2b_contig",   32'(last_v - first_v + 1), 32'd128);
    chk("b2b_partial",  32'(partial), 32'd0);

    // Four lanes: one slot per word
    d4_data = 32'hA1B2C3D4; d4_valid = 1'b1;
    @(negedge clk);
    d4_valid = 1'b0;
    wait_valid(4, "l4_seen", lat);
    collect(4, 8);
    chk("l4_lane0", cap[0], 32'h000000A1);
    chk("l4_lane1", cap[1], 32'h000000B2);
    chk("l4_lane2", cap[2], 32'h000000C3);
    chk("l4_lane3", cap[3], 32'h000000D4);
    chk("l4_vall",  32'(vall), 32'd1);
    collect(4, 8);
    chk("l4_com0", cap[0], 32'h000000BC);
    chk("l4_com3", cap[3], 32'h000000BC);
    chk("l4_vnone", 32'(vnone), 32'd1);

    // Single lane: four slots per word
    d1_data = 32'hDEADBEEF; d1_valid = 1'b1;
    @(negedge clk);
    d1_valid = 1'b0;
    wait_valid(1, "l1_seen", lat);
    collect(1, 32);
    chk("l1_lane0", cap[0], 32'hDEADBEEF);
    chk("l1_vall",  32'(vall), 32'd1);
    collect(1, 8);
    chk("l1_com0",  cap[0], 32'h000000BC);
    chk("l1_vnone", 32'(vnone), 32'd1);

    // Mid-word reset with two words still queued
    d2_valid = 1'b1; d2_data = 32'hCAFE0001;
    @(negedge clk);
    d2_data = 32'hCAFE0002;
    @(negedge clk);
    d2_data = 32'hCAFE0003;
    @(negedge clk);
    d2_valid = 1'b0;
    wait_valid(2, "mid_seen", lat);
    repeat (11) @(negedge clk);
    chk("mid_busy_vout", 32'(d2_vout), 32'h3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_dout",  32'(d2_dout),  32'h3);
    chk("mid_rst_vout",  32'(d2_vout),  32'h0);
    chk("mid_rst_ready", 32'(d2_ready), 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    collect(2, 64);
    chk("mid_post_lane0", cap[0], 32'hBCBCBCBC);
    chk("mid_post_lane1", cap[1], 32'hBCBCBCBC);
    chk("mid_post_vnone", 32'(vnone), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phy_tx_lane_serializer.md
# phy_tx_lane_serializer

Parametrised PHY-layer transmit datapath. Accepts DATA_W-bit words through a valid/ready handshake into a small word FIFO. Stripes each word's bytes round-robin across LANES lanes and serialises every lane MSB-first on a single bit-rate clock. When no data is available, lanes transmit the COM symbol (0xBC). It replaces the fixed two-lane striping, demux and serialiser chain with one single-clock block whose data width, lane count and buffer depth are configurable.

## Interface
- DATA_W, 32: input word width. Must be a multiple of 8*LANES.
- LANES, 2: number of serial lanes. Legal values are 1, 2, 4.
- DEPTH, 4: input FIFO depth in words. Must be a power of two, ≥2.
- COM, 8'hBC: idle/filler byte sent when no data is pending.
- clk  input  1  bit-rate clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- data_in  input  DATA_W  word to transmit.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  block can accept a word this cycle.
- data_out  output  LANES  serial bit per lane; bit l is lane l.
- valid_out  output  LANES  bit l is high while lane l is sending data bits, low while sending COM.

## Operation
- Derived constants: BYTES = DATA_W/8 and SLOTS = BYTES/LANES (bytes per lane per word).
- Byte k of a word is data_in[DATA_W-1-8k -: 8]; k=0 is the most significant byte. Byte k goes to lane k mod LANES in slot k div LANES.
- FIFO push happens when valid_in && ready_out.
  - ready_out = !full, decoded from registered FIFO state.
  - There is no bypass: when full, ready_out=0 even if a pop occurs in the same cycle.
  - valid_in while ready_out=0 is ignored, not an error.
- Each lane has an 8-bit shift register; data_out[l] = shreg[l][7]. On every edge where bit_cnt≠7, shreg shifts left, filling the LSB with 0.
- bit_cnt counts 0..7 and wraps. On the edge where bit_cnt==7, all lanes load a new byte together. This is the byte boundary.
- Load decision at each byte boundary, in priority order:
  1. BUSY and slot<SLOTS-1: slot++, load slot bytes from the held word, valid_out=all 1.
  2. Else if FIFO non-empty: pop into the word register, slot=0, BUSY=1, load slot-0 bytes, valid_out=all 1.
  3. Else: BUSY=0, load COM in all lanes, valid_out=all 0.
- State machine has two states.
  - IDLE (sending COM): goes to BUSY on a boundary with the FIFO non-empty.
  - BUSY: goes to IDLE on a boundary where slot==SLOTS-1 and the FIFO is empty.
  - BUSY with slot==SLOTS-1 and FIFO non-empty stays BUSY with slot=0; the stream has no COM gap.
- All lanes are byte-aligned: every lane's byte boundary falls on the same edge.
- Push and pop on the same edge are legal when not full. Occupancy is unchanged.

## Timing
- State while reset=0 (asynchronous):
  - FIFO empty, bit_cnt=0, slot=0, IDLE.
  - All shreg=COM, so data_out = all 1 (COM[7]).
  - valid_out=0, ready_out=1.
- After release, each lane emits COM bits 1,0,1,1,1,1,0,0 repeating; the first full COM symbol starts on the first post-reset cycle.
- Latency is counted from the push edge to the first data bit on data_out.
  - Minimum is 1 cycle: push on the edge taking bit_cnt to 7, pop on the next edge.
  - Maximum is 8 cycles when IDLE with an empty FIFO.
  - A word pushed on a boundary edge itself is not seen by that boundary's decision.
- Throughput: one word per 8*SLOTS cycles with a sustained FIFO supply.
- valid_out changes only on byte-boundary edges. It is high for exactly 8*SLOTS cycles per word.
- Reset asserted mid-byte or mid-word: the partial byte is abandoned, the FIFO is flushed and all outputs take reset values immediately.
- Full → non-full: ready_out rises the cycle after the popping edge.

## Test plan
- **Reset:** hold reset=0 for 5 cycles, then release.
  - During reset: data_out all 1, valid_out=0, ready_out=1.
  - After release: each lane shows 10111100 repeating with valid_out=0.
- **Single word, LANES=2, DATA_W=32:** push 0x11223344.
  - Lane0 sends 0x11 then 0x33; lane1 sends 0x22 then 0x44, MSB first.
  - valid_out=2'b11 for exactly 16 cycles, then COM.
- **Back-to-back, DEPTH=4:** hold valid_in=1 with 8 words 0x00000001..0x00000008.
  - ready_out drops when 4 words are queued.
  - All 8 words appear in order with no COM between them.
  - valid_out stays high for 128 contiguous cycles.
- **LANES=4:** push 0xA1B2C3D4.
  - Lanes 0..3 send A1, B2, C3, D4 in the same 8 cycles.
  - Then COM on all lanes.
- **LANES=1:** push 0xDEADBEEF.
  - Lane0 sends DE, AD, BE, EF over 32 cycles, then COM.
- **Mid-word reset:** assert reset during slot 1, bit 3 of a word with 2 more words queued.
  - Outputs go to reset values at once.
  - After release: COM only, and no residual data is ever sent.
